// File: rtl/ma_stage_lat.sv
// ma_stage_lat: memory-access stage with byte-addressed data memory, configurable load latency, fault detection and MA->WB register
module ma_stage_lat #(
    parameter int XLEN        = 32,
    parameter int DMEM_BYTES  = 4096,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ma,
    input  logic [XLEN-1:0] pc_ma,
    input  logic [XLEN-1:0] alu_out_ma,
    input  logic [XLEN-1:0] rs2_ma,
    input  logic [31:0]     inst_ma,
    input  logic            mem_rd,
    input  logic            mem_rw,
    input  logic [1:0]      wb_sel,
    input  logic            reg_write_en,
    output logic            stall_ma,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_mux_out,
    output logic [31:0]     inst_wb,
    output logic            rd_we_wb,
    output logic            fault_wb
);
    localparam int AW = $clog2(DMEM_BYTES);
    localparam int CW = 4;
    localparam bit MULTI = MEM_LATENCY > 1;
    // WAIT count value in the last cycle of a load, where the stall drops and WB captures
    localparam logic [CW-1:0] LAST = CW'(MULTI ? MEM_LATENCY - 2 : 0);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [7:0]      r_mem [DMEM_BYTES];
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_last;
    logic            w_access, w_legal, w_misal, w_range, w_fault, w_load, w_store;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_ld, w_sel_val;
    logic            w_unused;
    assign w_unused = &{1'b0, inst_ma[31:15], inst_ma[11:0]};
    assign w_f3     = inst_ma[14:12];
    assign w_idx    = alu_out_ma[AW-1:0];
    // w_last is the address of the final byte touched; checking both ends catches any carry past the top
    assign w_last   = alu_out_ma + XLEN'(w_f3[1] ? 3 : w_f3[0] ? 1 : 0);
    assign w_access = valid_ma & (mem_rd | mem_rw);
    assign w_legal  = mem_rd ? !(w_f3 inside {3'b011, 3'b110, 3'b111}) : (w_f3 < 3'b011);
    assign w_misal  = (w_f3[1:0] == 2'b01 & alu_out_ma[0]) | (w_f3[1:0] == 2'b10 & |alu_out_ma[1:0]);
    assign w_range  = (alu_out_ma >= XLEN'(DMEM_BYTES)) | (w_last >= XLEN'(DMEM_BYTES));
    assign w_fault  = w_access & (~w_legal | w_misal | w_range);
    assign w_load   = valid_ma & mem_rd & ~w_fault;
    assign w_store  = valid_ma & mem_rw & ~w_fault & ~stall_ma;
    assign w_word   = {r_mem[w_idx + AW'(3)], r_mem[w_idx + AW'(2)], r_mem[w_idx + AW'(1)], r_mem[w_idx]};
    // Load extension and write-back selection; faulting ops always write back zero
    always_comb begin
        w_ld = w_f3 == 3'b000 ? {{(XLEN-8){w_word[7]}}, w_word[7:0]} :
               w_f3 == 3'b001 ? {{(XLEN-16){w_word[15]}}, w_word[15:0]} :
               w_f3 == 3'b100 ? XLEN'(w_word[7:0]) :
               w_f3 == 3'b101 ? XLEN'(w_word[15:0]) :
                                {{(XLEN-31){w_word[31]}}, w_word[30:0]};
        w_sel_val = w_fault         ? '0 :
                    wb_sel == 2'b00 ? w_ld :
                    wb_sel == 2'b01 ? alu_out_ma :
                    wb_sel == 2'b10 ? pc_ma + XLEN'(4) : '0;
    end
    // Latency FSM: stall from the first load cycle until the final WAIT cycle
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        stall_ma    = 1'b0;
        if (r_state == IDLE) begin
            if (w_load && MULTI) begin
                stall_ma    = reset;
                w_state_nxt = WAIT;
                w_count_nxt = '0;
            end
        end else begin
            stall_ma    = reset & (r_count != LAST);
            w_count_nxt = r_count == LAST ? '0 : r_count + CW'(1);
            w_state_nxt = r_count == LAST ? IDLE : WAIT;
        end
    end
    // FSM state and cycle counter; reset discards a pending load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end
    // Little-endian store, single cycle; memory contents survive reset
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_idx] <= rs2_ma[7:0];
            if (w_f3[1] | w_f3[0]) r_mem[w_idx + AW'(1)] <= rs2_ma[15:8];
            if (w_f3[1]) begin
                r_mem[w_idx + AW'(2)] <= rs2_ma[23:16];
                r_mem[w_idx + AW'(3)] <= rs2_ma[31:24];
            end
        end
    end
    // MA->WB register: bubble while stalled, capture otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid   <= 1'b0;
            wb_mux_out <= '0;
            inst_wb    <= '0;
            rd_we_wb   <= 1'b0;
            fault_wb   <= 1'b0;
        end else if (stall_ma) begin
            wb_valid <= 1'b0;
            rd_we_wb <= 1'b0;
            fault_wb <= 1'b0;
        end else begin
            wb_valid   <= valid_ma;
            wb_mux_out <= w_sel_val;
            inst_wb    <= inst_ma;
            rd_we_wb   <= valid_ma & reg_write_en & ~w_fault;
            fault_wb   <= w_fault;
        end
    end
endmodule
